me_best_mv_select: RTL
======================

Name: me_best_mv_select

Overview:
- Downstream consumer of the PE-array SAD outputs in the DMT motion-estimation path.
- For each of the four 16x16 coding sub-blocks (CB1..CB4) of the current 32x32 block, tracks the minimum SAD and its motion vector over one search pass.
- After the search completes, streams four result beats to the MV/mode decision stage using a valid/ready handshake.

Parameters:
- SAD_W, 16, width of one candidate SAD value.
- MV_W, 7, signed width of each MV component (range -64..63).
- NUM_CB, 4, number of tracked sub-blocks; fixed at 4, index width 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- search_start  in  1  single-cycle pulse; opens a new search pass (accepted in IDLE only)
- sad_valid  in  1  candidate SAD present this cycle
- sad_cb  in  2  sub-block index of candidate (0=CB1 .. 3=CB4)
- sad_value  in  SAD_W  candidate SAD
- sad_mv_x  in  MV_W  signed candidate MV x
- sad_mv_y  in  MV_W  signed candidate MV y
- search_done  in  1  single-cycle pulse; last candidate has been (or is being) presented
- res_valid  out  1  result beat valid
- res_ready  in  1  downstream accepts beat
- res_cb  out  2  sub-block index of the beat
- res_sad  out  SAD_W  best SAD
- res_mv_x  out  MV_W  best MV x
- res_mv_y  out  MV_W  best MV y
- res_found  out  1  at least one candidate was seen for this CB
- busy  out  1  high in SEARCH or OUTPUT
- pass_done  out  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state=IDLE; all outputs 0.
  - Per-CB best_sad = all-ones, best_mv = 0, found = 0.
  - Beat counter = 0.
- States:
  - IDLE: search_start -> SEARCH. On entry to SEARCH, all four trackers are cleared to the reset values.
  - SEARCH: sad_valid samples are evaluated. search_done -> OUTPUT. search_start in this state is ignored.
  - OUTPUT: emits beats cb=0,1,2,3 in order. After the beat-3 handshake -> IDLE, with pass_done high for 1 cycle. search_start and sad_valid are ignored.
- Update rule, per sample for tracker[sad_cb]. Replace the stored best when either:
  - sad_value < best_sad, or
  - sad_value == best_sad and cost(mv) < cost(best_mv), where cost = |x| + |y| computed unsigned at MV_W+1 bits.
- Tie handling: on a full tie (equal SAD and equal cost), the earlier sample is kept.
- found is set on any sample for that CB, whether or not it replaces the best.
- Update latency: the tracker register updates on the clock edge that samples sad_valid. There is one sample per cycle at full throughput with no back-pressure on the input side.
- Simultaneous events:
  - sad_valid together with search_done in SEARCH: the sample is included, then the block enters OUTPUT.
  - search_start together with search_done in IDLE: search_start wins and search_done is ignored.
- Handshake:
  - res_valid rises the cycle after entering OUTPUT.
  - res_* are held stable while res_valid && !res_ready.
  - A beat advances on res_valid && res_ready.
  - Back-to-back beats are allowed, so the pass completes in 4 cycles when res_ready is held high.
- No candidates seen for a CB: res_sad = all-ones, mv = 0, res_found = 0.
- Asserting rst_n low mid-operation forces IDLE asynchronously and discards the current pass.
- busy = (state != IDLE).

Decomposition:
- Shared package me_pkg holds:
  - SAD_W, MV_W, NUM_CB.
  - The state enum {IDLE, SEARCH, OUTPUT}.
  - A typedef best_t {sad, mv_x, mv_y, found}.
  - Function mv_cost(x, y).
- Sub-module me_min_cmp: combinational compare of a candidate against the stored best_t. Outputs the replace flag; instantiated once, with its input selected by sad_cb.

Test Plan:
- Basic minimum: start; CB0 samples (sad, mv) = (500,3,-2), (120,5,5), (300,0,0); done; ready=1 -> beat0 = sad 120, mv (5,5), found=1. Beats 1-3 have sad 0xFFFF, found=0, and complete in 4 consecutive cycles; pass_done follows.
- Tie-break: CB2 samples (80,-4,3) then (80,1,-1) then (80,-1,1) -> beat2 = sad 80, mv (1,-1), because the first cost-2 sample is kept.
- Coincident last sample: CB3 (900,2,2) followed by (10,-7,0) presented in the same cycle as search_done -> beat3 = sad 10, mv (-7,0).
- Back-pressure: res_ready low for 5 cycles on beat1 -> res_valid stays high and res_* are stable; beat1 is consumed once ready rises; pass_done appears only after beat3.
- Ignored inputs: search_start and sad_valid (sad 1) asserted during OUTPUT -> results unchanged, no restart; a new search_start in IDLE clears the trackers.
- Reset mid-SEARCH: rst_n low for 1 cycle after 3 samples -> state IDLE, res_valid=0, busy=0; the next pass sees no stale best values.

Source files
------------

// File: rtl/me_pkg.sv
// Shared types, widths and helpers for the motion-estimation best-MV selector.
package me_pkg;

    localparam int SAD_W  = 16;
    localparam int MV_W   = 7;
    localparam int NUM_CB = 4;
    localparam int CB_W   = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    typedef struct packed {
        logic [SAD_W-1:0]       sad;
        logic signed [MV_W-1:0] mv_x;
        logic signed [MV_W-1:0] mv_y;
        logic                   found;
    } best_t;

    // Empty tracker: worst possible SAD, zero vector, nothing seen yet.
    localparam best_t BEST_RESET = '{
        sad:   {SAD_W{1'b1}},
        mv_x:  {MV_W{1'b0}},
        mv_y:  {MV_W{1'b0}},
        found: 1'b0
    };

    // |x| + |y| as an unsigned MV_W+1 bit value; -64 maps to 64 without overflow.
    function automatic logic [MV_W:0] mv_cost(input logic signed [MV_W-1:0] x,
                                              input logic signed [MV_W-1:0] y);
        logic [MV_W:0] ax;
        logic [MV_W:0] ay;
        ax = x[MV_W-1] ? ({1'b0, ~x} + {{MV_W{1'b0}}, 1'b1}) : {1'b0, x};
        ay = y[MV_W-1] ? ({1'b0, ~y} + {{MV_W{1'b0}}, 1'b1}) : {1'b0, y};
        return ax + ay;
    endfunction

endpackage

// File: rtl/me_min_cmp.sv
// Decides whether a candidate (SAD, MV) beats the currently stored best.
// Lower SAD wins; equal SAD falls back to the smaller MV cost; a full tie keeps the stored one.
module me_min_cmp
    import me_pkg::*;
(
    input  logic [SAD_W-1:0]       i_cand_sad,
    input  logic signed [MV_W-1:0] i_cand_mv_x,
    input  logic signed [MV_W-1:0] i_cand_mv_y,
    input  logic [SAD_W-1:0]       i_best_sad,
    input  logic signed [MV_W-1:0] i_best_mv_x,
    input  logic signed [MV_W-1:0] i_best_mv_y,
    output logic                   o_replace
);

    logic [MV_W:0] w_cand_cost;
    logic [MV_W:0] w_best_cost;

    assign w_cand_cost = mv_cost(i_cand_mv_x, i_cand_mv_y);
    assign w_best_cost = mv_cost(i_best_mv_x, i_best_mv_y);

    // Strict ordering on (SAD, cost) so that earlier samples survive full ties.
    always_comb begin
        o_replace = 1'b0;
        if (i_cand_sad < i_best_sad) begin
            o_replace = 1'b1;
        end else if ((i_cand_sad == i_best_sad) && (w_cand_cost < w_best_cost)) begin
            o_replace = 1'b1;
        end else begin
            o_replace = 1'b0;
        end
    end

endmodule

// File: rtl/me_best_mv_select.sv
// Tracks the best SAD/MV per 16x16 sub-block during a search pass, then streams
// four result beats (CB1..CB4) downstream over a valid/ready handshake.
module me_best_mv_select
    import me_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_search_start,
    input  logic                   i_sad_valid,
    input  logic [CB_W-1:0]        i_sad_cb,
    input  logic [SAD_W-1:0]       i_sad_value,
    input  logic signed [MV_W-1:0] i_sad_mv_x,
    input  logic signed [MV_W-1:0] i_sad_mv_y,
    input  logic                   i_search_done,
    output logic                   o_res_valid,
    input  logic                   i_res_ready,
    output logic [CB_W-1:0]        o_res_cb,
    output logic [SAD_W-1:0]       o_res_sad,
    output logic signed [MV_W-1:0] o_res_mv_x,
    output logic signed [MV_W-1:0] o_res_mv_y,
    output logic                   o_res_found,
    output logic                   o_busy,
    output logic                   o_pass_done
);

    state_t r_state;
    state_t w_state_nxt;

    best_t r_best [NUM_CB];
    best_t w_sel;

    logic [CB_W-1:0]        r_beat;
    logic [CB_W-1:0]        w_beat_nxt;
    logic                   r_res_valid;
    logic [CB_W-1:0]        r_res_cb;
    logic [SAD_W-1:0]       r_res_sad;
    logic signed [MV_W-1:0] r_res_mv_x;
    logic signed [MV_W-1:0] r_res_mv_y;
    logic                   r_res_found;
    logic                   r_pass_done;

    logic w_replace;
    logic w_start_pass;
    logic w_sample;
    logic w_load_first;
    logic w_accept;
    logic w_last_beat;

    assign w_sel        = r_best[i_sad_cb];
    assign w_start_pass = (r_state == IDLE) && i_search_start;
    assign w_sample     = (r_state == SEARCH) && i_sad_valid;
    assign w_load_first = (r_state == OUTPUT) && !r_res_valid;
    assign w_accept     = (r_state == OUTPUT) && r_res_valid && i_res_ready;
    assign w_last_beat  = w_accept && (r_beat == 2'd3);
    assign w_beat_nxt   = r_beat + 2'd1;

    me_min_cmp u_cmp (
        .i_cand_sad  (i_sad_value),
        .i_cand_mv_x (i_sad_mv_x),
        .i_cand_mv_y (i_sad_mv_y),
        .i_best_sad  (w_sel.sad),
        .i_best_mv_x (w_sel.mv_x),
        .i_best_mv_y (w_sel.mv_y),
        .o_replace   (w_replace)
    );

    // State register; reset drops any pass in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; start has priority over done in IDLE because IDLE ignores done.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (i_search_start) begin
                    w_state_nxt = SEARCH;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SEARCH: begin
                if (i_search_done) begin
                    w_state_nxt = OUTPUT;
                end else begin
                    w_state_nxt = SEARCH;
                end
            end
            OUTPUT: begin
                if (w_last_beat) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = OUTPUT;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Per-CB trackers: cleared when a pass opens, updated by SEARCH samples only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CB; i++) begin
                r_best[i] <= BEST_RESET;
            end
        end else if (w_start_pass) begin
            for (int i = 0; i < NUM_CB; i++) begin
                r_best[i] <= BEST_RESET;
            end
        end else if (w_sample) begin
            r_best[i_sad_cb].found <= 1'b1;
            if (w_replace) begin
                r_best[i_sad_cb].sad  <= i_sad_value;
                r_best[i_sad_cb].mv_x <= i_sad_mv_x;
                r_best[i_sad_cb].mv_y <= i_sad_mv_y;
            end
        end
    end

    // Result beat sequencer: first beat loads one cycle into OUTPUT, then advances per handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat      <= 2'd0;
            r_res_valid <= 1'b0;
            r_res_cb    <= 2'd0;
            r_res_sad   <= {SAD_W{1'b0}};
            r_res_mv_x  <= {MV_W{1'b0}};
            r_res_mv_y  <= {MV_W{1'b0}};
            r_res_found <= 1'b0;
            r_pass_done <= 1'b0;
        end else begin
            r_pass_done <= w_last_beat;
            if (w_start_pass) begin
                r_beat <= 2'd0;
            end else if (w_load_first) begin
                r_beat      <= 2'd0;
                r_res_valid <= 1'b1;
                r_res_cb    <= 2'd0;
                r_res_sad   <= r_best[0].sad;
                r_res_mv_x  <= r_best[0].mv_x;
                r_res_mv_y  <= r_best[0].mv_y;
                r_res_found <= r_best[0].found;
            end else if (w_accept) begin
                if (r_beat == 2'd3) begin
                    r_beat      <= 2'd0;
                    r_res_valid <= 1'b0;
                end else begin
                    r_beat      <= w_beat_nxt;
                    r_res_cb    <= w_beat_nxt;
                    r_res_sad   <= r_best[w_beat_nxt].sad;
                    r_res_mv_x  <= r_best[w_beat_nxt].mv_x;
                    r_res_mv_y  <= r_best[w_beat_nxt].mv_y;
                    r_res_found <= r_best[w_beat_nxt].found;
                end
            end
        end
    end

    assign o_res_valid = r_res_valid;
    assign o_res_cb    = r_res_cb;
    assign o_res_sad   = r_res_sad;
    assign o_res_mv_x  = r_res_mv_x;
    assign o_res_mv_y  = r_res_mv_y;
    assign o_res_found = r_res_found;
    assign o_pass_done = r_pass_done;
    assign o_busy      = (r_state != IDLE);

endmodule
